// File: rtl/b2_arb_pkg.sv
// Shared types and constants for the 16-requester round-robin arbiter.
package b2_arb_pkg;

  localparam int unsigned N             = 16;
  localparam int unsigned IDX_W         = 4;
  localparam int unsigned MAX_HOLD_DFLT = 15;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/b2_onehot_enc.sv
// Combinational 16-to-4 one-hot to binary encoder; all-zero input encodes to 0.
module b2_onehot_enc
  import b2_arb_pkg::*;
(
  input  logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (onehot[i]) begin
        idx = idx | IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/b2_rr_arbiter.sv
// Round-robin arbiter: 16 requesters, registered one-hot grant and index,
// released on done, request drop, disable or hold-time limit.
module b2_rr_arbiter
  import b2_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = MAX_HOLD_DFLT
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [N-1:0]     req,
  input  logic             done,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid,
  output logic             timeout
);

  localparam int unsigned HOLD_W   = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam int unsigned HOLD_LIM = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;

  arb_state_e        state, state_nxt;
  logic [IDX_W-1:0]  ptr, ptr_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic [N-1:0]      grant_nxt;
  logic [IDX_W-1:0]  idx_nxt;
  logic              timeout_nxt;

  logic              pick_found;
  logic [IDX_W-1:0]  pick_idx;

  logic              cause_dis, cause_done, cause_drop, cause_hold, release_any;

  // First set request at or after ptr, wrapping 15 -> 0
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!pick_found && req[ptr + IDX_W'(i)]) begin
        pick_found = 1'b1;
        pick_idx   = ptr + IDX_W'(i);
      end
    end
  end

  assign cause_dis   = !enable;
  assign cause_done  = done;
  assign cause_drop  = !req[grant_idx];
  assign cause_hold  = (MAX_HOLD != 0) && (hold_cnt == HOLD_W'(HOLD_LIM));
  assign release_any = cause_dis || cause_done || cause_drop || cause_hold;

  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    ptr_nxt     = ptr;
    hold_nxt    = hold_cnt;
    timeout_nxt = 1'b0;
    case (state)
      IDLE: begin
        grant_nxt = '0;
        if (enable && pick_found) begin
          state_nxt = GRANT;
          grant_nxt = N'(1) << pick_idx;
          ptr_nxt   = pick_idx + IDX_W'(1);
          hold_nxt  = '0;
        end
      end
      GRANT: begin
        if (release_any) begin
          state_nxt   = IDLE;
          grant_nxt   = '0;
          // Timeout is flagged only when the hold limit alone forced the release
          timeout_nxt = cause_hold && !(cause_dis || cause_done || cause_drop);
        end else if (hold_cnt != {HOLD_W{1'b1}}) begin
          hold_nxt = hold_cnt + HOLD_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  b2_onehot_enc u_enc (
    .onehot (grant_nxt),
    .idx    (idx_nxt)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      ptr         <= '0;
      hold_cnt    <= '0;
      grant       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      hold_cnt    <= hold_nxt;
      grant       <= grant_nxt;
      grant_idx   <= idx_nxt;
      grant_valid <= (state_nxt == GRANT);
      timeout     <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_b2_rr_arbiter.sv
// Directed bench for b2_rr_arbiter with hand-computed expectations.
module tb_b2_rr_arbiter;

  logic        clock;
  logic        reset_n;
  logic        enable;
  logic [15:0] req;
  logic        done;
  logic [15:0] grant;
  logic [3:0]  grant_idx;
  logic        grant_valid;
  logic        timeout;

  int checks = 0;
  int errors = 0;

  b2_rr_arbiter #(.MAX_HOLD(15)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .enable      (enable),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic check_idle(input string tag, input logic exp_to);
    check_eq({tag, "_grant"}, 32'(grant), 32'h0);
    check_eq({tag, "_idx"},   32'(grant_idx), 32'h0);
    check_eq({tag, "_valid"}, 32'(grant_valid), 32'h0);
    check_eq({tag, "_tout"},  32'(timeout), 32'(exp_to));
  endtask

  task automatic check_owner(input string tag, input int idx);
    check_eq({tag, "_grant"}, 32'(grant), 32'(16'h1 << idx));
    check_eq({tag, "_idx"},   32'(grant_idx), 32'(idx));
    check_eq({tag, "_valid"}, 32'(grant_valid), 32'h1);
  endtask

  initial begin
    reset_n = 1'b0;
    enable  = 1'b0;
    req     = '0;
    done    = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_idle("reset", 1'b0);
    @(negedge clock);
    reset_n = 1'b1;

    // Single requester 0
    step();
    enable = 1'b1;
    req    = 16'h0001;
    step();
    check_owner("req0", 0);
    req = 16'h0000;
    step();
    check_idle("req0_rel", 1'b0);

    // All requesting, done after each grant: 0..15 then 0, one dead cycle each
    do_reset();
    req = 16'hFFFF;
    for (int k = 0; k <= 16; k++) begin
      step();
      check_owner($sformatf("rr%0d", k), k % 16);
      done = 1'b1;
      step();
      done = 1'b0;
      check_idle($sformatf("rr%0d_gap", k), 1'b0);
    end
    req = 16'h0000;
    step();

    // Owner 5 drops its request; ptr moves to 6
    do_reset();
    req = 16'h0020;
    step();
    check_owner("own5", 5);
    req = 16'h0000;
    step();
    check_idle("own5_drop", 1'b0);
    req = 16'h0041;
    step();
    check_owner("ptr6", 6);
    req = 16'h0000;
    step();
    check_idle("ptr6_rel", 1'b0);

    // Hold limit: owner 3 held for exactly 15 cycles, then timeout pulse
    do_reset();
    req = 16'h0008;
    step();
    check_owner("hold_c1", 3);
    for (int c = 2; c <= 15; c++) begin
      if (c == 5) req = 16'h0009;
      step();
      check_owner($sformatf("hold_c%0d", c), 3);
      check_eq($sformatf("hold_c%0d_tout", c), 32'(timeout), 32'h0);
    end
    step();
    check_idle("hold_exp", 1'b1);
    step();
    check_owner("hold_next", 0);
    check_eq("hold_next_tout", 32'(timeout), 32'h0);
    req = 16'h0000;
    step();
    check_idle("hold_next_rel", 1'b0);

    // Async reset mid-grant of owner 9, then ptr restarts at 0
    do_reset();
    req = 16'h0200;
    step();
    check_owner("own9", 9);
    reset_n = 1'b0;
    #1;
    check_idle("async_rst", 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    req = 16'h8200;
    step();
    check_owner("post_rst", 9);
    req = 16'h0000;
    step();

    // Enable gating and drop of enable mid-grant
    do_reset();
    enable = 1'b0;
    req    = 16'h0010;
    step();
    check_idle("dis1", 1'b0);
    step();
    check_idle("dis2", 1'b0);
    enable = 1'b1;
    step();
    check_owner("en_on", 4);
    enable = 1'b0;
    step();
    check_idle("en_off", 1'b0);
    req = 16'h0000;
    step();

    // done while idle is ignored
    enable = 1'b1;
    done   = 1'b1;
    step();
    done = 1'b0;
    check_idle("done_idle", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
